rf_mp: RTL and testbench

Parametrised multi-port register file, the successor to the single-write 32x32 `rf`. It provides two combinational read ports, two synchronous write ports with fixed collision priority, optional same-cycle write-to-read bypass and a hardwired zero register. A per-register busy scoreboard lets the issue stage detect pending writes. It sits between decode (read/issue) and writeback (two result buses) in the CPU datapath.

---
 rtl/rf_mp.sv | 102 ++++++++++
 tb/tb_rf_mp.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_mp.sv
// rf_mp: multi-port register file with two combinational read ports, two
// synchronous write ports (port 1 wins collisions), optional write-to-read
// bypass, optional hardwired zero register and a per-register busy scoreboard.
module rf_mp #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    ra,
  input  logic [AW-1:0]    rb,
  output logic [WIDTH-1:0] qa,
  output logic [WIDTH-1:0] qb,
  output logic             busy_a,
  output logic             busy_b,
  input  logic             we0,
  input  logic [AW-1:0]    rw0,
  input  logic [WIDTH-1:0] rd0,
  input  logic             we1,
  input  logic [AW-1:0]    rw1,
  input  logic [WIDTH-1:0] rd1,
  input  logic             iss,
  input  logic [AW-1:0]    iss_rw
);

  localparam int unsigned Depth = 1 << AW;

  logic [WIDTH-1:0] mem_q [Depth];
  logic [WIDTH-1:0] mem_d [Depth];
  logic [Depth-1:0] busy_q, busy_d;
  logic             wr0_en, wr1_en, iss_en;
  logic [AW-1:0]    raddr [2];

  assign raddr[0] = ra;
  assign raddr[1] = rb;

  // Writes and issues aimed at a hardwired R0 are dropped here.
  always_comb begin
    wr0_en = we0 && !((ZERO_REG != 0) && (rw0 == '0));
    wr1_en = we1 && !((ZERO_REG != 0) && (rw1 == '0));
    iss_en = iss && !((ZERO_REG != 0) && (iss_rw == '0));
  end

  // Next register contents; port 1 is applied last so it wins a collision.
  always_comb begin
    mem_d = mem_q;
    if (wr0_en) mem_d[rw0] = rd0;
    if (wr1_en) mem_d[rw1] = rd1;
  end

  // Next scoreboard; a new issue overrides a retiring write to the same register.
  always_comb begin
    busy_d = busy_q;
    if (we0)    busy_d[rw0]    = 1'b0;
    if (we1)    busy_d[rw1]    = 1'b0;
    if (iss_en) busy_d[iss_rw] = 1'b1;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q  <= '{default: '0};
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic             hit0, hit1;
    logic [WIDTH-1:0] data;
    logic             busy;

    // Read mux: zero register, then port 1 bypass, port 0 bypass, storage.
    always_comb begin
      hit1 = (BYPASS != 0) && we1 && (rw1 == raddr[p]);
      hit0 = (BYPASS != 0) && we0 && (rw0 == raddr[p]);
      data = mem_q[raddr[p]];
      busy = busy_q[raddr[p]] && !(hit0 || hit1);
      if (rst) begin
        // Bypass must not leak write data while reset is held.
        data = '0;
        busy = 1'b0;
      end else if ((ZERO_REG != 0) && (raddr[p] == '0)) begin
        data = '0;
      end else if (hit1) begin
        data = rd1;
      end else if (hit0) begin
        data = rd0;
      end
    end
  end

  assign qa     = g_rd[0].data;
  assign qb     = g_rd[1].data;
  assign busy_a = g_rd[0].busy;
  assign busy_b = g_rd[1].busy;

endmodule

// File: tb/tb_rf_mp.sv
// Bench for rf_mp: a default instance and a BYPASS=0 instance share stimulus
// and one reference model; a 16-bit/8-entry instance without zero register
// gets directed checks.
module tb_rf_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [4:0]  ra, rb, rw0, rw1, iss_rw;
  logic [31:0] rd0, rd1;
  logic        we0, we1, iss;
  logic [31:0] qa, qb, qa_n, qb_n;
  logic        busy_a, busy_b, busy_a_n, busy_b_n;

  logic [2:0]  s_ra, s_rb, s_rw0, s_rw1, s_iss_rw;
  logic [15:0] s_rd0, s_rd1, s_qa, s_qb;
  logic        s_we0, s_we1, s_iss, s_busy_a, s_busy_b;

  int total = 0;
  int bad   = 0;

  // Reference state: register values and pending-write flags.
  logic [31:0] m_mem  [32];
  bit          m_busy [32];

  rf_mp u_dut (
    .clk(clk), .rst(rst), .ra(ra), .rb(rb), .qa(qa), .qb(qb),
    .busy_a(busy_a), .busy_b(busy_b),
    .we0(we0), .rw0(rw0), .rd0(rd0), .we1(we1), .rw1(rw1), .rd1(rd1),
    .iss(iss), .iss_rw(iss_rw)
  );

  rf_mp #(.BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .ra(ra), .rb(rb), .qa(qa_n), .qb(qb_n),
    .busy_a(busy_a_n), .busy_b(busy_b_n),
    .we0(we0), .rw0(rw0), .rd0(rd0), .we1(we1), .rw1(rw1), .rd1(rd1),
    .iss(iss), .iss_rw(iss_rw)
  );

  rf_mp #(.WIDTH(16), .AW(3), .ZERO_REG(0)) u_sm (
    .clk(clk), .rst(rst), .ra(s_ra), .rb(s_rb), .qa(s_qa), .qb(s_qb),
    .busy_a(s_busy_a), .busy_b(s_busy_b),
    .we0(s_we0), .rw0(s_rw0), .rd0(s_rd0), .we1(s_we1), .rw1(s_rw1), .rd1(s_rd1),
    .iss(s_iss), .iss_rw(s_iss_rw)
  );

  // Expected read data from the architectural rules.
  function automatic logic [31:0] exp_q(input logic [4:0] addr, input bit bypass);
    if (addr == 0) return 32'h0;
    if (bypass && we1 && rw1 == addr) return rd1;
    if (bypass && we0 && rw0 == addr) return rd0;
    return m_mem[addr];
  endfunction

  function automatic bit exp_busy(input logic [4:0] addr, input bit bypass);
    if (bypass && ((we1 && rw1 == addr) || (we0 && rw0 == addr))) return 1'b0;
    return m_busy[addr];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = 32'h0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; iss = 0; rw0 = 0; rw1 = 0; iss_rw = 0; rd0 = 0; rd1 = 0;
    s_we0 = 0; s_we1 = 0; s_iss = 0; s_rw0 = 0; s_rw1 = 0; s_iss_rw = 0;
    s_rd0 = 0; s_rd1 = 0;
  endtask

  // Apply this cycle's strobes to the model, then advance past the edge.
  task automatic tick();
    if (!rst) begin
      if (we0 && rw0 != 0) m_mem[rw0] = rd0;
      if (we1 && rw1 != 0) m_mem[rw1] = rd1;
      if (we0) m_busy[rw0] = 1'b0;
      if (we1) m_busy[rw1] = 1'b0;
      if (iss && iss_rw != 0) m_busy[iss_rw] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    model_clear();
    we0 = 1; rw0 = 3; rd0 = 32'hFF; iss = 1; iss_rw = 3; ra = 3; rb = 0;
    s_we0 = 1; s_rw0 = 3; s_rd0 = 16'hFF; s_ra = 3; s_rb = 0;
    #1;
    total++; if (qa !== 32'h0) begin bad++; $display("FAIL reset_qa got %h want 0", qa); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy_a); end
    total++; if (s_qa !== 16'h0) begin bad++; $display("FAIL reset_s_qa got %h want 0", s_qa); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    #1;
    total++; if (qa !== 32'h0) begin bad++; $display("FAIL reset_wr_drop got %h want 0", qa); end
    total++; if (qa_n !== 32'h0) begin bad++; $display("FAIL reset_wr_drop_nb got %h want 0", qa_n); end
    total++; if (busy_a_n !== 1'b0) begin bad++; $display("FAIL reset_iss_drop got %b want 0", busy_a_n); end
  endtask

  task automatic test_basic();
    idle(); we0 = 1; rw0 = 1; rd0 = 1; tick();
    rw0 = 2; rd0 = 2; tick();
    rw0 = 3; rd0 = 3; tick();
    rw0 = 0; rd0 = 2; tick();
    idle(); ra = 0; rb = 1; #1;
    total++; if (qa !== 32'd0) begin bad++; $display("FAIL basic_r0 got %h want 0", qa); end
    total++; if (qb !== 32'd1) begin bad++; $display("FAIL basic_r1 got %h want 1", qb); end
    total++; if (qa_n !== 32'd0) begin bad++; $display("FAIL basic_r0_nb got %h want 0", qa_n); end
    tick();
    ra = 2; rb = 3; #1;
    total++; if (qa !== 32'd2) begin bad++; $display("FAIL basic_r2 got %h want 2", qa); end
    total++; if (qb !== 32'd3) begin bad++; $display("FAIL basic_r3 got %h want 3", qb); end
    total++; if (qb_n !== 32'd3) begin bad++; $display("FAIL basic_r3_nb got %h want 3", qb_n); end
  endtask

  task automatic test_collision();
    idle();
    we0 = 1; we1 = 1; rw0 = 5; rw1 = 5; rd0 = 32'hAAAA_AAAA; rd1 = 32'h5555_5555; ra = 5;
    #1;
    total++; if (qa !== 32'h5555_5555) begin bad++; $display("FAIL coll_byp got %h want 55555555", qa); end
    total++; if (qa_n !== 32'h0) begin bad++; $display("FAIL coll_nobyp got %h want 0", qa_n); end
    tick();
    idle(); #1;
    total++; if (qa !== 32'h5555_5555) begin bad++; $display("FAIL coll got %h want 55555555", qa); end
    total++; if (qa_n !== 32'h5555_5555) begin bad++; $display("FAIL coll_nb got %h want 55555555", qa_n); end
  endtask

  task automatic test_bypass();
    idle();
    we0 = 1; rw0 = 7; rd0 = 32'h1234; ra = 7;
    #1;
    total++; if (qa !== 32'h1234) begin bad++; $display("FAIL byp_same got %h want 1234", qa); end
    total++; if (qa_n !== 32'h0) begin bad++; $display("FAIL nobyp_same got %h want 0", qa_n); end
    tick();
    idle(); #1;
    total++; if (qa_n !== 32'h1234) begin bad++; $display("FAIL nobyp_next got %h want 1234", qa_n); end
  endtask

  task automatic test_scoreboard();
    idle();
    iss = 1; iss_rw = 4; ra = 4; #1;
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL sb_pre got %b want 0", busy_a); end
    tick();
    idle(); #1;
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL sb_set got %b want 1", busy_a); end
    total++; if (busy_a_n !== 1'b1) begin bad++; $display("FAIL sb_set_nb got %b want 1", busy_a_n); end
    we0 = 1; rw0 = 4; rd0 = 32'h44; #1;
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL sb_wr_byp got %b want 0", busy_a); end
    total++; if (busy_a_n !== 1'b1) begin bad++; $display("FAIL sb_wr_nb got %b want 1", busy_a_n); end
    tick();
    idle(); #1;
    total++; if (busy_a_n !== 1'b0) begin bad++; $display("FAIL sb_clr_nb got %b want 0", busy_a_n); end
    iss = 1; iss_rw = 4; we1 = 1; rw1 = 4; rd1 = 32'h45;
    tick();
    idle(); #1;
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL sb_set_wins got %b want 1", busy_a); end
    iss = 1; iss_rw = 0; rb = 0;
    tick();
    idle(); #1;
    total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL sb_r0 got %b want 0", busy_b); end
  endtask

  task automatic test_reset_mid();
    idle();
    we0 = 1; rw0 = 1; rd0 = 32'h11; we1 = 1; rw1 = 2; rd1 = 32'h22; tick();
    idle(); we0 = 1; rw0 = 3; rd0 = 32'h33; iss = 1; iss_rw = 2; tick();
    idle(); ra = 2; rb = 3; #1;
    total++; if (busy_a !== 1'b1 || qb !== 32'h33) begin
      bad++; $display("FAIL rmid_pre got busy=%b q=%h want 1 33", busy_a, qb);
    end
    rst = 1'b1;
    model_clear();
    #1;
    total++; if (qa !== 32'h0 || busy_a !== 1'b0) begin
      bad++; $display("FAIL rmid_now got q=%h busy=%b want 0 0", qa, busy_a);
    end
    for (int a = 0; a < 32; a++) begin
      ra = a[4:0]; rb = 5'(31 - a); #1;
      total++;
      if (qa !== 0 || qb !== 0 || qa_n !== 0 || qb_n !== 0 ||
          busy_a !== 0 || busy_b !== 0 || busy_a_n !== 0 || busy_b_n !== 0) begin
        bad++;
        $display("FAIL rmid_addr%0d got %h %h %h %h %b%b%b%b want all 0", a, qa, qb, qa_n,
                 qb_n, busy_a, busy_b, busy_a_n, busy_b_n);
      end
    end
    we0 = 1; rw0 = 6; rd0 = 32'h77;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(); ra = 6; #1;
    total++; if (qa !== 32'h0 || qa_n !== 32'h0) begin
      bad++; $display("FAIL rmid_wr_drop got %h %h want 0", qa, qa_n);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      we0 = 1'($urandom); we1 = 1'($urandom); iss = 1'($urandom_range(3) == 0);
      rw0 = 5'($urandom_range(7)); rw1 = 5'($urandom_range(7));
      iss_rw = 5'($urandom_range(7));
      ra = 5'($urandom_range(7)); rb = 5'($urandom_range(31));
      rd0 = $urandom; rd1 = $urandom;
      #1;
      total++;
      if (qa !== exp_q(ra, 1) || qb !== exp_q(rb, 1) ||
          busy_a !== exp_busy(ra, 1) || busy_b !== exp_busy(rb, 1)) begin
        bad++;
        $display("FAIL rand_byp cyc%0d got %h %h %b %b want %h %h %b %b", n, qa, qb, busy_a,
                 busy_b, exp_q(ra, 1), exp_q(rb, 1), exp_busy(ra, 1), exp_busy(rb, 1));
      end
      total++;
      if (qa_n !== exp_q(ra, 0) || qb_n !== exp_q(rb, 0) ||
          busy_a_n !== exp_busy(ra, 0) || busy_b_n !== exp_busy(rb, 0)) begin
        bad++;
        $display("FAIL rand_nobyp cyc%0d got %h %h %b %b want %h %h %b %b", n, qa_n, qb_n,
                 busy_a_n, busy_b_n, exp_q(ra, 0), exp_q(rb, 0), exp_busy(ra, 0),
                 exp_busy(rb, 0));
      end
      tick();
    end
    idle();
  endtask

  task automatic test_small_cfg();
    idle();
    s_we0 = 1; s_rw0 = 0; s_rd0 = 16'hBEEF; s_we1 = 1; s_rw1 = 7; s_rd1 = 16'h0001;
    s_iss = 1; s_iss_rw = 0;
    tick();
    idle(); s_ra = 0; s_rb = 7; #1;
    total++; if (s_qa !== 16'hBEEF) begin bad++; $display("FAIL small_r0 got %h want beef", s_qa); end
    total++; if (s_qb !== 16'h0001) begin bad++; $display("FAIL small_r7 got %h want 0001", s_qb); end
    total++; if (s_busy_a !== 1'b1) begin bad++; $display("FAIL small_r0_busy got %b want 1", s_busy_a); end
  endtask

  initial begin
    ra = 0; rb = 0; s_ra = 0; s_rb = 0;
    test_reset();
    test_basic();
    test_collision();
    test_bypass();
    test_scoreboard();
    test_reset_mid();
    test_random();
    test_small_cfg();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
